// File: rtl/product_accumulator_if.sv
// Stream bundle between the multiplier-side producer, the accumulator and
// the byte sink: product input handshake plus the result byte output.
interface product_accumulator_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] product;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       overflow;

    // Producer/sink side: offers products and takes result bytes
    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, out_data, out_last, overflow
    );

    // Accumulator side: takes products and offers result bytes
    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, out_data, out_last, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums N_SAMPLES unsigned 8-bit products into a saturating accumulator and
// emits each frame total as a little-endian two-byte burst.
module product_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clear,
    product_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        OUT_LO = 2'd1,
        OUT_HI = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [7:0]       LAST_IDX = 8'(N_SAMPLES - 1);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [7:0]       cnt;
    logic [7:0]       cnt_next;
    logic             ovf;
    logic             ovf_next;
    logic             byte_valid;
    logic             byte_valid_next;
    logic [7:0]       byte_data;
    logic [7:0]       byte_data_next;
    logic             byte_last;
    logic             byte_last_next;

    logic [ACC_W:0]   sum_wide;
    logic [7:0]       acc_hi;
    logic             accept;

    // The extra top bit of the sum is the carry that signals saturation;
    // acc <= 2^ACC_W-1 and product <= 255 so one spare bit is enough.
    assign sum_wide = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, bus.product};
    assign acc_hi   = 8'(acc >> 8);

    // Ready only while collecting samples and nothing above normal
    // operation (reset, clear, freeze) is in force this cycle.
    assign bus.in_ready = rst_n & ena & ~clear & (state == ACCUM);
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = byte_valid;
    assign bus.out_data  = byte_data;
    assign bus.out_last  = byte_last;
    assign bus.overflow  = ovf;

    // Next-state and next-output decode; clear beats enable, and with ena
    // low every register simply keeps its value.
    always_comb begin
        state_next      = state;
        acc_next        = acc;
        cnt_next        = cnt;
        ovf_next        = ovf;
        byte_valid_next = byte_valid;
        byte_data_next  = byte_data;
        byte_last_next  = byte_last;

        if (clear) begin
            state_next      = ACCUM;
            acc_next        = '0;
            cnt_next        = '0;
            ovf_next        = 1'b0;
            byte_valid_next = 1'b0;
            byte_data_next  = 8'h00;
            byte_last_next  = 1'b0;
        end else if (ena) begin
            case (state)
                ACCUM: begin
                    byte_valid_next = 1'b0;
                    byte_last_next  = 1'b0;
                    if (accept) begin
                        if (sum_wide[ACC_W]) begin
                            acc_next = ACC_MAX;
                            ovf_next = 1'b1;
                        end else begin
                            acc_next = sum_wide[ACC_W-1:0];
                        end
                        cnt_next = cnt + 8'd1;
                        if (cnt == LAST_IDX) begin
                            state_next      = OUT_LO;
                            byte_valid_next = 1'b1;
                            byte_data_next  = acc_next[7:0];
                        end
                    end
                end
                OUT_LO: begin
                    if (bus.out_ready) begin
                        state_next     = OUT_HI;
                        byte_data_next = acc_hi;
                        byte_last_next = 1'b1;
                    end
                end
                OUT_HI: begin
                    if (bus.out_ready) begin
                        state_next      = ACCUM;
                        acc_next        = '0;
                        cnt_next        = '0;
                        ovf_next        = 1'b0;
                        byte_valid_next = 1'b0;
                        byte_data_next  = 8'h00;
                        byte_last_next  = 1'b0;
                    end
                end
                default: begin
                    state_next      = ACCUM;
                    byte_valid_next = 1'b0;
                    byte_last_next  = 1'b0;
                end
            endcase
        end
    end

    // State, accumulator and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_last  <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            ovf        <= ovf_next;
            byte_valid <= byte_valid_next;
            byte_data  <= byte_data_next;
            byte_last  <= byte_last_next;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios plus
// randomized traffic, all compared against a queue-based frame model.
module tb_product_accumulator;

    localparam int ACC_W   = 12;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic clear;

    product_accumulator_if bus4 ();
    product_accumulator_if bus20 ();
    product_accumulator_if bus1 ();

    product_accumulator #(.N_SAMPLES(4), .ACC_W(ACC_W)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .bus(bus4)
    );
    product_accumulator #(.N_SAMPLES(20), .ACC_W(ACC_W)) dut20 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .bus(bus20)
    );
    product_accumulator #(.N_SAMPLES(1), .ACC_W(ACC_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .bus(bus1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int sel = 0;
    int m_n = 4;
    int m_frame[$];
    int m_bytes[$];

    logic        obs_ready;
    logic        exp_ready;
    logic        hs_seen;
    logic [7:0]  hs_data;
    logic        hs_last;
    logic [10:0] obs_raw;
    logic [10:0] obs_out;
    logic [10:0] exp_out;

    function automatic int frame_total();
        int t = 0;
        foreach (m_frame[i]) t += m_frame[i];
        return t;
    endfunction

    function automatic void model_edge(input logic rstn_i, input logic en_i, input logic clr_i,
                                       input logic v_i, input logic [7:0] p_i, input logic ordy_i);
        if (!rstn_i || clr_i) begin
            m_frame.delete();
            m_bytes.delete();
        end else if (en_i) begin
            if (m_bytes.size() == 0) begin
                if (v_i) begin
                    m_frame.push_back(int'(p_i));
                    if (m_frame.size() == m_n) begin
                        int s;
                        s = (frame_total() > ACC_MAX) ? ACC_MAX : frame_total();
                        m_bytes.push_back(s % 256);
                        m_bytes.push_back(s / 256);
                    end
                end
            end else if (ordy_i) begin
                void'(m_bytes.pop_front());
                if (m_bytes.size() == 0) m_frame.delete();
            end
        end
    endfunction

    function automatic logic [11:0] peek();
        case (sel)
            0:       return {bus4.in_ready, bus4.out_valid, bus4.out_data, bus4.out_last, bus4.overflow};
            1:       return {bus20.in_ready, bus20.out_valid, bus20.out_data, bus20.out_last, bus20.overflow};
            default: return {bus1.in_ready, bus1.out_valid, bus1.out_data, bus1.out_last, bus1.overflow};
        endcase
    endfunction

    task automatic step(input logic rstn_i, input logic en_i, input logic clr_i,
                        input logic v_i, input logic [7:0] p_i, input logic ordy_i);
        logic [11:0] pre;
        logic [11:0] post;
        logic        ev;
        rst_n = rstn_i;
        ena   = en_i;
        clear = clr_i;
        bus4.in_valid   = (sel == 0) && v_i;
        bus4.product    = p_i;
        bus4.out_ready  = (sel == 0) ? ordy_i : 1'b1;
        bus20.in_valid  = (sel == 1) && v_i;
        bus20.product   = p_i;
        bus20.out_ready = (sel == 1) ? ordy_i : 1'b1;
        bus1.in_valid   = (sel == 2) && v_i;
        bus1.product    = p_i;
        bus1.out_ready  = (sel == 2) ? ordy_i : 1'b1;
        #1;
        exp_ready = rstn_i && en_i && !clr_i && (m_bytes.size() == 0);
        pre       = peek();
        obs_ready = pre[11];
        hs_seen   = pre[10] && ordy_i && rstn_i && en_i && !clr_i;
        hs_data   = pre[9:2];
        hs_last   = pre[1];
        @(posedge clk);
        #1;
        model_edge(rstn_i, en_i, clr_i, v_i, p_i, ordy_i);
        post    = peek();
        obs_raw = post[10:0];
        ev      = (m_bytes.size() != 0);
        exp_out = {ev, ev ? 8'(m_bytes[0]) : 8'h00, ev && (m_bytes.size() == 1), frame_total() > ACC_MAX};
        obs_out = {post[10], ev ? post[9:2] : 8'h00, ev ? post[1] : 1'b0, post[0]};
    endtask

    task automatic start_dut(input int s, input int n);
        sel = s;
        m_n = n;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        sel = 0;
        m_n = 4;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, (i == 0), 1'b0, 1'b1, 8'd77, 1'b1);
            compared++;
            if (obs_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset.in_ready cycle %0d: got %b want 0", i, obs_ready);
            end
            compared++;
            if (obs_raw !== 11'h000) begin
                mismatched++;
                $display("[TB] FAIL reset.outputs cycle %0d: got %h want 000", i, obs_raw);
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        compared++;
        if (obs_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset.release_ready: got %b want 1", obs_ready);
        end
    endtask

    task automatic test_basic();
        int         prods[4] = '{10, 20, 30, 40};
        int         zero_ready = 0;
        int         first_valid = -1;
        logic [7:0] got[$];
        logic       lasts[$];
        start_dut(0, 4);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, (i < 4), (i < 4) ? 8'(prods[i]) : 8'h00, 1'b1);
            if (obs_ready === 1'b0) zero_ready++;
            if (hs_seen) begin
                got.push_back(hs_data);
                lasts.push_back(hs_last);
            end
            if (obs_raw[10] === 1'b1 && first_valid < 0) first_valid = i;
            compared++;
            if (obs_ready !== exp_ready) begin
                mismatched++;
                $display("[TB] FAIL basic.in_ready cycle %0d: got %b want %b", i, obs_ready, exp_ready);
            end
            compared++;
            if (obs_out !== exp_out) begin
                mismatched++;
                $display("[TB] FAIL basic.outputs cycle %0d: got %h want %h", i, obs_out, exp_out);
            end
        end
        compared++;
        if (got.size() != 2 || got[0] !== 8'h64 || got[1] !== 8'h00 || lasts[0] !== 1'b0 || lasts[1] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic.bytes: got %0d bytes %p lasts %p, want 64/0 then 00/1", got.size(), got, lasts);
        end
        compared++;
        if (first_valid != 3 || zero_ready != 2) begin
            mismatched++;
            $display("[TB] FAIL basic.timing: got first_valid %0d idle_ready %0d, want 3 and 2", first_valid, zero_ready);
        end
    endtask

    task automatic test_no_sat();
        logic [7:0] got[$];
        start_dut(0, 4);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, (i < 4), 8'd225, 1'b1);
            if (hs_seen) got.push_back(hs_data);
            compared++;
            if (obs_out !== exp_out) begin
                mismatched++;
                $display("[TB] FAIL nosat.outputs cycle %0d: got %h want %h", i, obs_out, exp_out);
            end
            compared++;
            if (obs_raw[0] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL nosat.overflow cycle %0d: got %b want 0", i, obs_raw[0]);
            end
        end
        compared++;
        if (got.size() != 2 || got[0] !== 8'h84 || got[1] !== 8'h03) begin
            mismatched++;
            $display("[TB] FAIL nosat.bytes: got %p want 84 03", got);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic       v;
        logic [7:0] p;
        logic       r;
        start_dut(0, 4);
        for (int i = 0; i < 16; i++) begin
            v = (i < 13);
            p = (i < 4) ? 8'd225 : (i < 9) ? 8'd99 : 8'd1;
            r = !(i >= 4 && i <= 6);
            step(1'b1, 1'b1, 1'b0, v, p, r);
            if (hs_seen) got.push_back(hs_data);
            compared++;
            if (obs_ready !== exp_ready || obs_out !== exp_out) begin
                mismatched++;
                $display("[TB] FAIL backpressure.cycle %0d: got ready %b out %h want ready %b out %h",
                         i, obs_ready, obs_out, exp_ready, exp_out);
            end
            if (i >= 4 && i <= 6) begin
                compared++;
                if (obs_raw[10:1] !== {1'b1, 8'h84, 1'b0} || obs_ready !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL backpressure.hold cycle %0d: got out %h ready %b want valid=1 data=84 last=0 ready=0",
                             i, obs_raw, obs_ready);
                end
            end
        end
        compared++;
        if (got.size() != 4 || got[0] !== 8'h84 || got[1] !== 8'h03 || got[2] !== 8'h04 || got[3] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL backpressure.bytes: got %p want 84 03 04 00", got);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] got[$];
        logic       want_ovf;
        start_dut(1, 20);
        for (int i = 0; i < 23; i++) begin
            step(1'b1, 1'b1, 1'b0, (i < 20), 8'd225, 1'b1);
            if (hs_seen) got.push_back(hs_data);
            compared++;
            if (obs_out !== exp_out) begin
                mismatched++;
                $display("[TB] FAIL saturation.outputs cycle %0d: got %h want %h", i, obs_out, exp_out);
            end
            want_ovf = (i >= 18 && i <= 20);
            compared++;
            if (obs_raw[0] !== want_ovf) begin
                mismatched++;
                $display("[TB] FAIL saturation.overflow cycle %0d: got %b want %b", i, obs_raw[0], want_ovf);
            end
        end
        compared++;
        if (got.size() != 2 || got[0] !== 8'hFF || got[1] !== 8'h0F) begin
            mismatched++;
            $display("[TB] FAIL saturation.bytes: got %p want ff 0f", got);
        end
    endtask

    task automatic test_clear();
        logic [7:0] got[$];
        start_dut(0, 4);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, (i == 2), (i < 7), (i < 3) ? 8'd50 : 8'd1, 1'b1);
            if (hs_seen) got.push_back(hs_data);
            compared++;
            if (obs_ready !== exp_ready || obs_out !== exp_out) begin
                mismatched++;
                $display("[TB] FAIL clear.cycle %0d: got ready %b out %h want ready %b out %h",
                         i, obs_ready, obs_out, exp_ready, exp_out);
            end
            if (i == 2) begin
                compared++;
                if (obs_ready !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL clear.ready_in_clear: got %b want 0", obs_ready);
                end
            end
        end
        compared++;
        if (got.size() != 2 || got[0] !== 8'h04 || got[1] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL clear.bytes: got %p want 04 00", got);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_dut(0, 4);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, (i < 4), 8'd7, (i != 5));
        end
        compared++;
        if (obs_raw[10] !== 1'b1 || obs_raw[1] !== 1'b1 || obs_raw[9:2] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL resetmid.in_out_hi: got %h want valid=1 data=00 last=1", obs_raw);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        compared++;
        if (obs_raw !== 11'h000) begin
            mismatched++;
            $display("[TB] FAIL resetmid.dropped: got %h want 000", obs_raw);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        compared++;
        if (obs_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL resetmid.ready_after: got %b want 1", obs_ready);
        end
    endtask

    task automatic test_enable();
        logic [7:0] got[$];
        int         first_valid = -1;
        logic       en;
        start_dut(0, 4);
        for (int i = 0; i < 10; i++) begin
            en = !(i == 2 || i == 3);
            step(1'b1, en, 1'b0, (i < 6), 8'd5, 1'b1);
            if (hs_seen) got.push_back(hs_data);
            if (obs_raw[10] === 1'b1 && first_valid < 0) first_valid = i;
            compared++;
            if (obs_ready !== exp_ready || obs_out !== exp_out) begin
                mismatched++;
                $display("[TB] FAIL enable.cycle %0d: got ready %b out %h want ready %b out %h",
                         i, obs_ready, obs_out, exp_ready, exp_out);
            end
        end
        compared++;
        if (got.size() != 2 || got[0] !== 8'h14 || got[1] !== 8'h00 || first_valid != 5) begin
            mismatched++;
            $display("[TB] FAIL enable.result: got %p first_valid %0d want 14 00 and 5", got, first_valid);
        end
    endtask

    task automatic test_random();
        logic       rn;
        logic       en;
        logic       cl;
        logic       v;
        logic [7:0] p;
        logic       r;
        for (int s = 0; s < 3; s++) begin
            start_dut(s, (s == 0) ? 4 : (s == 1) ? 20 : 1);
            for (int i = 0; i < 400; i++) begin
                rn = ($urandom_range(0, 99) != 0);
                en = ($urandom_range(0, 9) != 0);
                cl = ($urandom_range(0, 49) == 0);
                v  = ($urandom_range(0, 3) != 0);
                p  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
                r  = ($urandom_range(0, 2) != 0);
                step(rn, en, cl, v, p, r);
                compared++;
                if (obs_ready !== exp_ready) begin
                    mismatched++;
                    $display("[TB] FAIL random.in_ready n=%0d cycle %0d: got %b want %b", m_n, i, obs_ready, exp_ready);
                end
                compared++;
                if (obs_out !== exp_out) begin
                    mismatched++;
                    $display("[TB] FAIL random.outputs n=%0d cycle %0d: got %h want %h", m_n, i, obs_out, exp_out);
                end
            end
        end
    endtask

    // Scenario sequence and final summary
    initial begin
        $display("[TB] product_accumulator bench starting");
        test_reset();
        test_basic();
        test_no_sat();
        test_backpressure();
        test_saturation();
        test_clear();
        test_reset_mid_frame();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
